// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: shared types and defaults for the 1010 pattern transmitter
package moore_seq_pkg;
  localparam int PAT_W = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1010;
  localparam int CNT_W = 4;
  localparam int BC_W = $clog2(PAT_W);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/moore_seq_tx_1010_if.sv
// moore_seq_tx_1010_if: request/abort controls and serial output bundle
interface moore_seq_tx_1010_if;
  logic start;
  logic [moore_seq_pkg::CNT_W-1:0] rep;
  logic abort;
  logic x_out;
  logic x_valid;
  logic busy;
  logic done;
  modport master(output start, rep, abort, input x_out, x_valid, busy, done);
  modport slave(input start, rep, abort, output x_out, x_valid, busy, done);
endinterface

// File: rtl/moore_seq_shreg.sv
// moore_seq_shreg: pattern shift/reload register with its bit counter
module moore_seq_shreg
  import moore_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  output logic msb,
  output logic last
);
  logic [PAT_W-1:0] sreg;
  logic [BC_W-1:0] bit_cnt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg <= PATTERN;
      bit_cnt <= BC_W'(PAT_W - 1);
    end else if (shift) begin
      sreg <= {sreg[PAT_W-2:0], 1'b0};
      bit_cnt <= bit_cnt - 1'b1;
    end
  end
  assign msb = sreg[PAT_W-1];
  assign last = bit_cnt == '0;
endmodule

// File: rtl/moore_seq_tx_1010.sv
// moore_seq_tx_1010: Moore FSM sending PATTERN rep times MSB first
module moore_seq_tx_1010
  import moore_seq_pkg::*;
(
  input logic clk,
  input logic rst,
  moore_seq_tx_1010_if.slave s
);
  state_t state, state_n;
  logic [CNT_W-1:0] reps_left;
  logic msb, last, load, shift, reload;
  moore_seq_shreg u_shreg (
    .clk(clk),
    .rst(rst),
    .load(load),
    .shift(shift),
    .msb(msb),
    .last(last)
  );
  // abort outranks every SHIFT transition, including the final bit
  always_comb begin
    reload = state == SHIFT && !s.abort && last && reps_left > CNT_W'(1);
    load = (state == IDLE && s.start) || reload;
    shift = state == SHIFT && !s.abort && !last;
    state_n = state == IDLE ? (s.start ? SHIFT : IDLE) :
              state == SHIFT ? (s.abort ? IDLE : (last && !reload) ? DONE : SHIFT) :
              IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      reps_left <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && s.start) reps_left <= s.rep == '0 ? CNT_W'(1) : s.rep;
      else if (reload) reps_left <= reps_left - 1'b1;
    end
  end
  assign s.x_out = state == SHIFT && msb;
  assign s.x_valid = state == SHIFT;
  assign s.busy = state == SHIFT;
  assign s.done = state == DONE;
endmodule

// File: tb/tb_moore_seq_tx_1010.sv
// tb_moore_seq_tx_1010: directed and random checks against a bit-position model
module tb_moore_seq_tx_1010;
  import moore_seq_pkg::*;
  logic clk = 0;
  logic rst = 0;
  int errors = 0;
  int checks = 0;
  moore_seq_tx_1010_if ifc ();
  moore_seq_tx_1010 dut (.clk(clk), .rst(rst), .s(ifc));
  always #5 clk = ~clk;

  bit m_known = 0, m_act = 0, m_done = 0;
  int m_pos = 0, m_tot = 0;
  always @(posedge clk) begin
    if (!rst) begin
      m_known = 1; m_act = 0; m_done = 0;
    end else if (m_done) m_done = 0;
    else if (m_act) begin
      if (ifc.abort) m_act = 0;
      else if (m_pos == m_tot - 1) begin m_act = 0; m_done = 1; end
      else m_pos++;
    end else if (ifc.start) begin
      m_act = 1; m_pos = 0;
      m_tot = PAT_W * (ifc.rep == 0 ? 1 : int'(ifc.rep));
    end
  end

  always @(negedge clk) begin
    logic [PAT_W-1:0] pat;
    logic [3:0] exp, got;
    if (m_known) begin
      pat = PATTERN;
      exp = m_act ? {pat[PAT_W-1-(m_pos%PAT_W)], 3'b110} : {3'b000, m_done};
      got = {ifc.x_out, ifc.x_valid, ifc.busy, ifc.done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model t=%0t {x_out,x_valid,busy,done} got=%b exp=%b", $time, got, exp);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  logic [15:0] vbits;
  logic [3:0] win;
  int vcnt, dcnt, dfirst, bcnt, hits;

  task automatic capture(input int n, input int ab, input int rs, input logic hold);
    vbits = 0; win = 0; vcnt = 0; dcnt = 0; dfirst = -1; bcnt = 0; hits = 0;
    for (int i = 0; i < n; i++) begin
      if (ifc.x_valid) begin
        vbits = {vbits[14:0], ifc.x_out};
        win = {win[2:0], ifc.x_out};
        vcnt++;
        if (vcnt >= 4 && win == 4'b1010) hits++;
      end
      if (ifc.done) begin dcnt++; if (dfirst < 0) dfirst = i; end
      if (ifc.busy) bcnt++;
      ifc.abort = (i == ab);
      rst = (i != rs);
      ifc.start = hold;
      ifc.rep = CNT_W'($urandom);
      @(negedge clk);
    end
    ifc.abort = 0; rst = 1; ifc.start = 0;
  endtask

  task automatic go(input int r, input logic hold);
    ifc.rep = CNT_W'(r);
    ifc.start = 1;
    @(negedge clk);
    ifc.start = hold;
  endtask

  initial begin
    ifc.start = 1; ifc.rep = 1; ifc.abort = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ifc.x_out, ifc.x_valid, ifc.busy, ifc.done}, 0);
    rst = 1; ifc.start = 0;
    capture(3, -1, -1, 0);
    chk("reset_start_no_tx", vcnt, 0);
    go(1, 0); capture(7, -1, -1, 0);
    chk("basic_bits", vbits[3:0], 4'b1010);
    chk("basic_valid", vcnt, 4);
    chk("basic_done_cycle", dfirst, 4);
    chk("basic_busy", bcnt, 4);
    go(3, 0); capture(15, -1, -1, 0);
    chk("rep3_bits", vbits[11:0], 12'hAAA);
    chk("rep3_valid", vcnt, 12);
    chk("rep3_done", dcnt, 1);
    chk("rep3_done_cycle", dfirst, 12);
    chk("rep3_hits", hits, 5);
    go(0, 0); capture(7, -1, -1, 0);
    chk("rep0_valid", vcnt, 4);
    chk("rep0_done", dcnt, 1);
    go(2, 0); capture(8, 2, -1, 0);
    chk("abort_valid", vcnt, 3);
    chk("abort_done", dcnt, 0);
    go(1, 0); capture(6, -1, -1, 0);
    chk("post_abort_bits", vbits[3:0], 4'b1010);
    go(2, 0); capture(8, -1, 1, 0);
    chk("rst_mid_valid", vcnt, 2);
    chk("rst_mid_done", dcnt, 0);
    rst = 0; ifc.start = 1; @(negedge clk);
    rst = 1; ifc.start = 0; capture(4, -1, -1, 0);
    chk("rst_with_start", vcnt, 0);
    go(1, 1); capture(6, -1, -1, 1);
    chk("held_start_valid", vcnt, 4);
    chk("held_start_done", dcnt, 1);
    capture(2, -1, -1, 0);
    chk("held_start_restart", vcnt, 2);
    capture(8, -1, -1, 0);
    for (int i = 0; i < 600; i++) begin
      ifc.start = $urandom_range(0, 3) == 0;
      ifc.rep = CNT_W'($urandom);
      ifc.abort = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 39) != 0;
      @(negedge clk);
    end
    rst = 1; ifc.start = 0; ifc.abort = 0;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
